// File: rtl/romix_loop_ctrl.sv
// Scrypt ROMix outer-loop sequencer: N scratchpad writes interleaved with BlockMix,
// then N data-dependent reads feeding BlockMix with X xor V[j].
module romix_loop_ctrl #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [31:0]          x_index,
    input  logic                 bm_done,
    output logic                 bm_start,
    output logic                 bm_xor_sel,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_we,
    output logic                 mem_re,
    output logic [ADDR_BITS-1:0] iter,
    output logic                 phase,
    output logic                 busy,
    output logic                 done
);

    // One-hot so that every strobe is a single flop bit (or OR of two) and cannot glitch.
    typedef enum logic [7:0] {
        S_IDLE     = 8'h01,
        S_WR_STORE = 8'h02,
        S_WR_MIX   = 8'h04,
        S_WR_WAIT  = 8'h08,
        S_RD_ADDR  = 8'h10,
        S_RD_MIX   = 8'h20,
        S_RD_WAIT  = 8'h40,
        S_DONE     = 8'h80
    } state_t;

    localparam int B_IDLE     = 0;
    localparam int B_WR_STORE = 1;
    localparam int B_WR_MIX   = 2;
    localparam int B_RD_ADDR  = 4;
    localparam int B_RD_MIX   = 5;
    localparam int B_RD_WAIT  = 6;
    localparam int B_DONE     = 7;

    localparam logic [ADDR_BITS-1:0] ITER_LAST = {ADDR_BITS{1'b1}};

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   iter_q, iter_d;
    logic                   phase_q, phase_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic                   iter_last;

    // Only the low ADDR_BITS of Integerify(X) select the block (mod N).
    logic unused_x_hi;
    assign unused_x_hi = ^x_index[31:ADDR_BITS];

    assign iter_last = (iter_q == ITER_LAST);

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        phase_d = phase_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WR_STORE;
                    iter_d  = '0;
                    phase_d = 1'b0;
                end
            end
            S_WR_STORE: state_d = S_WR_MIX;
            S_WR_MIX:   state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (bm_done) begin
                    if (iter_last) begin
                        state_d = S_RD_ADDR;
                        iter_d  = '0;
                        phase_d = 1'b1;
                    end else begin
                        state_d = S_WR_STORE;
                        iter_d  = iter_q + 1'b1;
                    end
                end
            end
            S_RD_ADDR:  state_d = S_RD_MIX;
            S_RD_MIX:   state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (bm_done) begin
                    if (iter_last) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD_ADDR;
                        iter_d  = iter_q + 1'b1;
                    end
                end
            end
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        // Cancel overrides everything, including a same-cycle bm_done or start.
        if (abort) begin
            state_d = S_IDLE;
            iter_d  = '0;
            phase_d = 1'b0;
        end
    end

    // Address is presented combinationally in the strobe cycle and held afterwards.
    always_comb begin
        mem_addr_d = mem_addr_q;
        if (state_q[B_WR_STORE]) begin
            mem_addr_d = iter_q;
        end else if (state_q[B_RD_ADDR]) begin
            mem_addr_d = x_index[ADDR_BITS-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            iter_q     <= '0;
            phase_q    <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            phase_q    <= phase_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign mem_we     = state_q[B_WR_STORE];
    assign mem_re     = state_q[B_RD_ADDR];
    assign bm_start   = state_q[B_WR_MIX] | state_q[B_RD_MIX];
    assign bm_xor_sel = state_q[B_RD_MIX] | state_q[B_RD_WAIT];
    assign mem_addr   = mem_addr_d;
    assign iter       = iter_q;
    assign phase      = phase_q;
    assign busy       = ~state_q[B_IDLE];
    assign done       = state_q[B_DONE];

endmodule

// File: tb/tb_romix_loop_ctrl.sv
// Directed bench for romix_loop_ctrl at N = 4 with a behavioural BlockMix responder.
module tb_romix_loop_ctrl;

    localparam int AB = 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [31:0]   x_index;
    logic          bm_done;
    logic          bm_start;
    logic          bm_xor_sel;
    logic [AB-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic [AB-1:0] iter;
    logic          phase;
    logic          busy;
    logic          done;

    romix_loop_ctrl #(.ADDR_BITS(AB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .x_index    (x_index),
        .bm_done    (bm_done),
        .bm_start   (bm_start),
        .bm_xor_sel (bm_xor_sel),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .iter       (iter),
        .phase      (phase),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    int cyc;
    int done_cyc;
    int done_cnt;
    int busy_cnt;
    int bm_cnt;
    int lat_wr;
    int lat_rd;
    bit stray_en;
    bit abort_arm;
    bit start_arm;
    bit rst_arm;
    bit stop_hit;

    logic [AB-1:0] we_q[$];
    logic [AB-1:0] re_q[$];
    logic          xs_q[$];
    logic [31:0]   xv[4];

    // One clock: sample outputs 1 time unit after the edge, then drive next inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (abort) stop_hit = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (mem_we) we_q.push_back(mem_addr);
        if (mem_re) re_q.push_back(mem_addr);
        if (bm_start && phase) xs_q.push_back(bm_xor_sel);
        if (bm_cnt > 0) begin
            bm_cnt--;
            bm_done = (bm_cnt == 0);
        end else begin
            bm_done = stray_en && (mem_we || mem_re);
        end
        if (bm_start) bm_cnt = phase ? lat_rd : lat_wr;
        if (abort_arm && bm_done && !phase && iter == 2'd3) begin
            abort = 1'b1;
            abort_arm = 1'b0;
        end
        if (start_arm && mem_we && !phase && iter == 2'd2) begin
            start = 1'b1;
            start_arm = 1'b0;
        end
        if (rst_arm && mem_re && phase && iter == 2'd1) begin
            stop_hit = 1'b1;
            rst_arm = 1'b0;
        end
        x_index = xv[re_q.size() % 4];
    endtask

    // Start is sampled at the end of cycle 0, so the first busy cycle is cycle 1.
    task automatic run_job(input int budget);
        we_q.delete();
        re_q.delete();
        xs_q.delete();
        done_cyc = -1;
        done_cnt = 0;
        busy_cnt = 0;
        bm_cnt   = 0;
        bm_done  = 1'b0;
        stop_hit = 1'b0;
        cyc      = 0;
        start    = 1'b1;
        tick();
        while (done_cyc < 0 && cyc < budget && !stop_hit) tick();
        $display("job: done_cyc=%0d busy_cycles=%0d writes=%0d reads=%0d", done_cyc, busy_cnt, we_q.size(), re_q.size());
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bm_start, bm_xor_sel, mem_we, mem_re, busy, done} !== 6'b0) begin
            $display("FAIL reset_strobes got=%b want=000000", {bm_start, bm_xor_sel, mem_we, mem_re, busy, done});
            n_bad++;
        end
        n_cmp++;
        if ({mem_addr, iter, phase} !== 5'b0) begin
            $display("FAIL reset_addr_iter_phase got=%b want=00000", {mem_addr, iter, phase});
            n_bad++;
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            $display("FAIL reset_idle_busy got=%b want=0", busy);
            n_bad++;
        end
        $display("reset: checked");
    endtask

    task automatic test_basic_job();
        lat_wr = 1;
        lat_rd = 1;
        run_job(60);
        n_cmp++;
        if (done_cyc !== 25) begin
            $display("FAIL basic_done_cycle got=%0d want=25", done_cyc);
            n_bad++;
        end
        n_cmp++;
        if (busy_cnt !== 25) begin
            $display("FAIL basic_busy_cycles got=%0d want=25", busy_cnt);
            n_bad++;
        end
        n_cmp++;
        if (we_q.size() !== 4 || re_q.size() !== 4) begin
            $display("FAIL basic_strobe_counts got we=%0d re=%0d want 4/4", we_q.size(), re_q.size());
            n_bad++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (we_q[i] !== i[AB-1:0]) begin
                    $display("FAIL basic_we_addr[%0d] got=%0d want=%0d", i, we_q[i], i);
                    n_bad++;
                end
            end
        end
        tick();
        n_cmp++;
        if ({busy, done, iter, phase} !== 5'b00_111) begin
            $display("FAIL basic_post_done got busy=%b done=%b iter=%0d phase=%b want 0,0,3,1", busy, done, iter, phase);
            n_bad++;
        end
        n_cmp++;
        if (done_cnt !== 1) begin
            $display("FAIL basic_done_count got=%0d want=1", done_cnt);
            n_bad++;
        end
    endtask

    task automatic test_read_addr();
        logic [AB-1:0] exp_a[4];
        exp_a[0] = 2'd2;
        exp_a[1] = 2'd1;
        exp_a[2] = 2'd3;
        exp_a[3] = 2'd0;
        lat_wr = 1;
        lat_rd = 1;
        run_job(60);
        tick();
        n_cmp++;
        if (re_q.size() !== 4 || xs_q.size() !== 4) begin
            $display("FAIL rd_counts got re=%0d xor=%0d want 4/4", re_q.size(), xs_q.size());
            n_bad++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (re_q[i] !== exp_a[i]) begin
                    $display("FAIL rd_addr[%0d] got=%0d want=%0d", i, re_q[i], exp_a[i]);
                    n_bad++;
                end
                n_cmp++;
                if (xs_q[i] !== 1'b1) begin
                    $display("FAIL rd_xor_sel[%0d] got=%b want=1", i, xs_q[i]);
                    n_bad++;
                end
            end
        end
    endtask

    task automatic test_latency_stray();
        lat_wr   = 5;
        lat_rd   = 1;
        stray_en = 1'b1;
        run_job(100);
        stray_en = 1'b0;
        tick();
        n_cmp++;
        if (done_cyc !== 41) begin
            $display("FAIL lat_done_cycle got=%0d want=41", done_cyc);
            n_bad++;
        end
        n_cmp++;
        if (we_q.size() !== 4 || re_q.size() !== 4) begin
            $display("FAIL lat_strobe_counts got we=%0d re=%0d want 4/4", we_q.size(), re_q.size());
            n_bad++;
        end
        n_cmp++;
        if (done_cnt !== 1) begin
            $display("FAIL lat_done_count got=%0d want=1", done_cnt);
            n_bad++;
        end
    endtask

    task automatic test_abort();
        lat_wr    = 1;
        lat_rd    = 1;
        abort_arm = 1'b1;
        run_job(60);
        n_cmp++;
        if (!stop_hit) begin
            $display("FAIL abort_not_reached got stop=%b want=1", stop_hit);
            n_bad++;
        end
        n_cmp++;
        if ({busy, iter, phase} !== 4'b0) begin
            $display("FAIL abort_state got busy=%b iter=%0d phase=%b want 0,0,0", busy, iter, phase);
            n_bad++;
        end
        repeat (3) tick();
        n_cmp++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            $display("FAIL abort_no_done got done_cnt=%0d busy=%b want 0,0", done_cnt, busy);
            n_bad++;
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            $display("FAIL abort_start_idle got busy=%b want=0", busy);
            n_bad++;
        end
        run_job(60);
        n_cmp++;
        if (done_cyc !== 25) begin
            $display("FAIL abort_rerun_done got=%0d want=25", done_cyc);
            n_bad++;
        end
        tick();
    endtask

    task automatic test_start_busy();
        lat_wr    = 1;
        lat_rd    = 1;
        start_arm = 1'b1;
        run_job(60);
        tick();
        n_cmp++;
        if (start_arm !== 1'b0) begin
            $display("FAIL busy_start_not_injected got arm=%b want=0", start_arm);
            n_bad++;
        end
        n_cmp++;
        if (done_cyc !== 25 || done_cnt !== 1) begin
            $display("FAIL busy_start_done got cyc=%0d cnt=%0d want 25/1", done_cyc, done_cnt);
            n_bad++;
        end
        n_cmp++;
        if (we_q.size() !== 4) begin
            $display("FAIL busy_start_we_count got=%0d want=4", we_q.size());
            n_bad++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (we_q[i] !== i[AB-1:0]) begin
                    $display("FAIL busy_start_we_addr[%0d] got=%0d want=%0d", i, we_q[i], i);
                    n_bad++;
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        lat_wr  = 1;
        lat_rd  = 1;
        rst_arm = 1'b1;
        run_job(60);
        n_cmp++;
        if (!stop_hit || mem_addr !== 2'd1) begin
            $display("FAIL rst_mid_setup got stop=%b addr=%0d want 1,1", stop_hit, mem_addr);
            n_bad++;
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bm_start, bm_xor_sel, mem_we, mem_re, busy, done} !== 6'b0) begin
            $display("FAIL rst_mid_strobes got=%b want=000000", {bm_start, bm_xor_sel, mem_we, mem_re, busy, done});
            n_bad++;
        end
        n_cmp++;
        if ({mem_addr, iter, phase} !== 5'b0) begin
            $display("FAIL rst_mid_addr_iter_phase got=%b want=00000", {mem_addr, iter, phase});
            n_bad++;
        end
        bm_cnt  = 0;
        bm_done = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        run_job(60);
        n_cmp++;
        if (done_cyc !== 25) begin
            $display("FAIL rst_mid_rerun_done got=%0d want=25", done_cyc);
            n_bad++;
        end
        tick();
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        start     = 1'b0;
        abort     = 1'b0;
        bm_done   = 1'b0;
        stray_en  = 1'b0;
        abort_arm = 1'b0;
        start_arm = 1'b0;
        rst_arm   = 1'b0;
        lat_wr    = 1;
        lat_rd    = 1;
        bm_cnt    = 0;
        xv[0]     = 32'hDEADBEE6;
        xv[1]     = 32'h0000_0005;
        xv[2]     = 32'hFFFF_FFFF;
        xv[3]     = 32'h0000_0000;
        x_index   = xv[0];
        rst       = 1'b1;

        test_reset();
        test_basic_job();
        test_read_addr();
        test_latency_stray();
        test_abort();
        test_start_busy();
        test_rst_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
